mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one unified memory port between the CPU's instruction port (imem) and data port (dmem). The pipeline stalls until every one of its active requests has responded in the same cycle. The arbiter therefore serves requests as a batch: it serializes them onto the single downstream port, buffers the results, and returns all responses together. It sits between the CPU top level and the cache/memory model.

## Interface
- No parameters; address/data 32 bits, mask 4 bits.
- clk  in  1  single clock, all state rising-edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- imem_address  in  32  fetch address; imem_read  in  1  fetch request (level, held until response).
- imem_rdata  out  32  fetched word; imem_resp  out  1  fetch done.
- dmem_address  in  32; dmem_read  in  1; dmem_write  in  1; dmem_wmask  in  4; dmem_wdata  in  32  data request (level, held until response).
- dmem_rdata  out  32; dmem_resp  out  1  data done.
- mem_address  out  32; mem_read  out  1; mem_write  out  1; mem_wmask  out  4; mem_wdata  out  32  downstream request (registered).
- mem_rdata  in  32; mem_resp  in  1  downstream completion, one-cycle pulse.

## Operation
- States: IDLE, DMEM, IMEM, RESP.
- **IDLE:** on clk edge, snapshot the batch: pend_d = dmem_read|dmem_write, pend_i = imem_read.
  - Capture address, wdata, wmask and read/write for the pending ports.
  - Next state: DMEM if pend_d, else IMEM if pend_i, else IDLE.
- **DMEM:** downstream outputs driven from the dmem capture.
  - When mem_resp=1: latch mem_rdata into dbuf (store 0 for writes).
  - Then go to IMEM if pend_i, else RESP.
- **IMEM:** mem_read=1 with the imem capture. When mem_resp=1: latch into ibuf, go to RESP.
- **RESP:** for exactly one cycle, drive imem_resp=pend_i and dmem_resp=pend_d, with rdata from ibuf/dbuf. Then go to IDLE.
- Ordering is fixed: dmem before imem within a batch.
- Upstream inputs are ignored outside IDLE. Requests that appear mid-batch join the next batch.
- dmem_read and dmem_write both high: treated as a write.
- mem_read/mem_write are never both 1. They are never high in IDLE or RESP.
- Upstream rdata outputs are 0 whenever the matching resp is 0.

## Timing
- Reset (async assert): state=IDLE; pend_*, buffers, and all outputs = 0. Any in-flight downstream transaction is abandoned, and the downstream block is reset with the same signal.
- Latency, with downstream latency L cycles from request to mem_resp:
  - Single-port batch: 1 (IDLE) + L + 1 (RESP) cycles.
  - Dual-port batch: 1 + 2L + 1 cycles.
- Downstream outputs change only on clk edges.
- mem_resp is honored only in DMEM or IMEM; a mem_resp in any other state is ignored.
- Back-to-back: the next IDLE sample occurs the cycle after RESP, so the minimum gap between batches is 1 cycle.
- Reset deasserted with requests present: first capture on the first edge after release.

## Configuration
- ARB_BYPASS_EN defined: a single-port batch skips RESP.
  - In the cycle mem_resp=1, the matching upstream resp=1 and its rdata=mem_rdata, combinationally.
  - The state returns to IDLE on that edge.
  - Single-port latency becomes 1 + L. Dual-port batches are unchanged.
- Undefined: every batch passes through RESP; all upstream outputs are registered.

## Structure
- Shared package rv32i_types: add enum arb_state_t {IDLE, DMEM, IMEM, RESP} and struct arb_req_t {addr, wdata, wmask, rd, wr}.
- One sub-module, arb_port_buf, instantiated twice:
  - Holds the captured arb_req_t, the pend flag and the rdata buffer.
  - Has load and clear strobes from the FSM.

## Test plan
- Reset with imem_read=1 held, rst released: mem_read=1 and mem_address=imem_address starting the cycle after the first post-reset edge. Downstream L=2 returns 0x00000013 → imem_resp=1 and imem_rdata=0x00000013 for exactly one cycle, then IDLE.
- Simultaneous imem_read (0x1000) and dmem_read (0x2000):
  - Downstream sees 0x2000 first, then 0x1000.
  - imem_resp and dmem_resp rise in the same cycle, with correct respective data.
- dmem_write to 0x2004, wmask=4'b0011, wdata=0xDEADBEEF:
  - mem_write=1 with the identical mask and data; mem_read=0.
  - dmem_rdata=0 at response.
- Assert rst low while in DMEM awaiting mem_resp: all outputs are 0 immediately (async). A subsequent stray mem_resp=1 produces no upstream resp.
- dmem_read raised while in IMEM serving a batch: not served in the current batch; served in the following batch after RESP.
- With ARB_BYPASS_EN, imem-only batch, L=1: imem_resp in the same cycle as mem_resp (total 2 cycles from request). Without the macro: 3 cycles.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared CPU types; holds the memory arbiter state encoding and captured request record.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DMEM = 2'd1,
        IMEM = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        rd;
        logic        wr;
    } arb_req_t;

endpackage

// File: rtl/arb_port_buf.sv
// Per-port batch slot: captured request, pending flag and returned read data.
module arb_port_buf
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_pend,
    input  arb_req_t    i_req,
    input  logic        i_rdata_load,
    input  logic [31:0] i_rdata,
    input  logic        i_clear,
    output logic        o_pend,
    output arb_req_t    o_req,
    output logic [31:0] o_rdata
);

    logic        r_pend;
    arb_req_t    r_req;
    logic [31:0] r_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend  <= 1'b0;
            r_req   <= '0;
            r_rdata <= '0;
        end else if (i_clear) begin
            r_pend  <= 1'b0;
            r_req   <= '0;
            r_rdata <= '0;
        end else if (i_load) begin
            // idle ports keep an all-zero record so nothing stale reaches the bus
            r_pend  <= i_pend;
            r_req   <= i_pend ? i_req : '0;
            r_rdata <= '0;
        end else if (i_rdata_load) begin
            r_rdata <= i_rdata;
        end
    end

    assign o_pend  = r_pend;
    assign o_req   = r_req;
    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_arbiter.sv
// Batches imem/dmem requests onto one memory port (dmem first) and answers them together.
// Define ARB_BYPASS_EN to let single-port batches answer in the mem_resp cycle, skipping RESP.
module mem_arbiter
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_address,
    input  logic        imem_read,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_address,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    arb_state_t  r_state;
    arb_req_t    r_mem_req;

    arb_req_t    w_dreq_in, w_ireq_in, w_dreq, w_ireq;
    logic        w_pend_d, w_pend_i, w_load, w_clear, w_done;
    logic        w_resp_d, w_resp_i;
    logic [31:0] w_dbuf, w_ibuf, w_d_rdata;

    // read+write together is a write
    assign w_dreq_in = '{addr: dmem_address, wdata: dmem_wdata, wmask: dmem_wmask,
                         rd: dmem_read & ~dmem_write, wr: dmem_write};
    assign w_ireq_in = '{addr: imem_address, wdata: 32'd0, wmask: 4'd0, rd: 1'b1, wr: 1'b0};

    assign w_load    = (r_state == IDLE);
    assign w_clear   = (r_state == RESP) | w_done;
    assign w_d_rdata = w_dreq.wr ? 32'd0 : mem_rdata;

    arb_port_buf u_dbuf (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_pend       (dmem_read | dmem_write),
        .i_req        (w_dreq_in),
        .i_rdata_load ((r_state == DMEM) & mem_resp),
        .i_rdata      (w_d_rdata),
        .i_clear      (w_clear),
        .o_pend       (w_pend_d),
        .o_req        (w_dreq),
        .o_rdata      (w_dbuf)
    );

    arb_port_buf u_ibuf (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_pend       (imem_read),
        .i_req        (w_ireq_in),
        .i_rdata_load ((r_state == IMEM) & mem_resp),
        .i_rdata      (mem_rdata),
        .i_clear      (w_clear),
        .o_pend       (w_pend_i),
        .o_req        (w_ireq),
        .o_rdata      (w_ibuf)
    );

    assign w_resp_d = (r_state == RESP) & w_pend_d;
    assign w_resp_i = (r_state == RESP) & w_pend_i;

`ifdef ARB_BYPASS_EN
    logic w_byp_d, w_byp_i;
    assign w_byp_d    = (r_state == DMEM) & mem_resp & ~w_pend_i;
    assign w_byp_i    = (r_state == IMEM) & mem_resp & ~w_pend_d;
    assign w_done     = w_byp_d | w_byp_i;
    assign dmem_resp  = w_resp_d | w_byp_d;
    assign imem_resp  = w_resp_i | w_byp_i;
    assign dmem_rdata = w_resp_d ? w_dbuf : (w_byp_d ? w_d_rdata : 32'd0);
    assign imem_rdata = w_resp_i ? w_ibuf : (w_byp_i ? mem_rdata : 32'd0);
`else
    assign w_done     = 1'b0;
    assign dmem_resp  = w_resp_d;
    assign imem_resp  = w_resp_i;
    assign dmem_rdata = w_resp_d ? w_dbuf : 32'd0;
    assign imem_rdata = w_resp_i ? w_ibuf : 32'd0;
`endif

    // downstream request register is reloaded every cycle from the slot being served
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_mem_req <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (dmem_read | dmem_write) begin
                        r_state   <= DMEM;
                        r_mem_req <= w_dreq_in;
                    end else if (imem_read) begin
                        r_state   <= IMEM;
                        r_mem_req <= w_ireq_in;
                    end else begin
                        r_mem_req <= '0;
                    end
                end
                DMEM: begin
                    if (!mem_resp) begin
                        r_mem_req <= w_dreq;
                    end else if (w_pend_i) begin
                        r_state   <= IMEM;
                        r_mem_req <= w_ireq;
                    end else begin
                        r_state   <= w_done ? IDLE : RESP;
                        r_mem_req <= '0;
                    end
                end
                IMEM: begin
                    if (!mem_resp) begin
                        r_mem_req <= w_ireq;
                    end else begin
                        r_state   <= w_done ? IDLE : RESP;
                        r_mem_req <= '0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= '0;
                end
            endcase
        end
    end

    assign mem_address = r_mem_req.addr;
    assign mem_read    = r_mem_req.rd;
    assign mem_write   = r_mem_req.wr;
    assign mem_wmask   = r_mem_req.wmask;
    assign mem_wdata   = r_mem_req.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: downstream responder checks requests, monitor checks batch responses.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_address = '0;
    logic        imem_read = 1'b0;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_address = '0;
    logic        dmem_read = 1'b0;
    logic        dmem_write = 1'b0;
    logic [3:0]  dmem_wmask = '0;
    logic [31:0] dmem_wdata = '0;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;

`ifdef ARB_BYPASS_EN
    localparam int GAP1 = 0;
    localparam int LAT1 = 2;
`else
    localparam int GAP1 = 1;
    localparam int LAT1 = 3;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } dn_t;

    typedef struct {
        logic        ir;
        logic        dr;
        logic [31:0] idat;
        logic [31:0] ddat;
        int          gap;
    } up_t;

    dn_t dn_q[$];
    up_t up_q[$];
    int  total = 0;
    int  bad = 0;
    int  ncyc = 0;
    int  last_mr = -100;
    int  stray_req = 0;

    mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .imem_address (imem_address),
        .imem_read    (imem_read),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .dmem_address (dmem_address),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_wmask   (dmem_wmask),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wmask    (mem_wmask),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // downstream memory model: serves one request at a time after its latency
    initial begin : responder
        dn_t cur;
        int  cnt;
        int  stray_ack;
        logic busy;
        busy = 1'b0;
        cnt = 0;
        stray_ack = 0;
        cur = '{32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1};
        forever begin
            @(posedge clk);
            #1;
            if (mem_resp) begin
                mem_resp = 1'b0;
                mem_rdata = '0;
            end
            if (!rst) begin
                busy = 1'b0;
            end else if (stray_ack != stray_req) begin
                stray_ack = stray_req;
                mem_resp = 1'b1;
                mem_rdata = 32'hBAD0_BAD0;
            end else begin
                chk("rd_wr_exclusive", {95'd0, mem_read & mem_write}, 96'd0);
                if (!busy && (mem_read || mem_write)) begin
                    if (dn_q.size() == 0) begin
                        chk("dn_unexpected", {64'd0, mem_address}, 96'd0);
                    end else begin
                        cur = dn_q.pop_front();
                        chk("dn_req", {26'd0, mem_address, mem_read, mem_write, mem_wmask, mem_wdata},
                            {26'd0, cur.addr, cur.rd, cur.wr, cur.mask, cur.wdata});
                        busy = 1'b1;
                        cnt = cur.lat;
                    end
                end
                if (busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        mem_resp = 1'b1;
                        mem_rdata = cur.rdata;
                        busy = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : monitor
        up_t e;
        forever begin
            @(negedge clk);
            ncyc++;
            if (mem_resp) last_mr = ncyc;
            chk("rdata_idle", {94'd0, (!imem_resp && imem_rdata != 0), (!dmem_resp && dmem_rdata != 0)}, 96'd0);
            if (imem_resp || dmem_resp) begin
                if (up_q.size() == 0) begin
                    chk("unexpected_resp", {94'd0, imem_resp, dmem_resp}, 96'd0);
                end else begin
                    e = up_q.pop_front();
                    chk("resp_flags", {94'd0, imem_resp, dmem_resp}, {94'd0, e.ir, e.dr});
                    chk("imem_rdata", {64'd0, imem_rdata}, {64'd0, e.ir ? e.idat : 32'd0});
                    chk("dmem_rdata", {64'd0, dmem_rdata}, {64'd0, e.dr ? e.ddat : 32'd0});
                    chk("resp_gap", 96'(ncyc - last_mr), 96'(e.gap));
                end
            end
        end
    end

    task automatic wait_resp(input string nm, output int n);
        n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            n++;
            if (imem_resp || dmem_resp) break;
            if (k == 59) begin
                total++;
                bad++;
                $display("FAIL %s timeout waited=%0d cycles", nm, n);
            end
        end
    endtask

    initial begin : stim
        int n;
        imem_read = 1'b1;
        imem_address = 32'h0000_0100;
        #1;
        chk("reset_outputs", {29'd0, mem_read, mem_write, imem_resp, dmem_resp, mem_address},
            96'd0);
        dn_q.push_back('{32'h0000_0100, 1'b1, 1'b0, 4'd0, 32'd0, 32'h0000_0013, 2});
        up_q.push_back('{1'b1, 1'b0, 32'h0000_0013, 32'd0, GAP1});
        @(negedge clk);
        @(negedge clk);
        chk("held_in_reset", {95'd0, mem_read}, 96'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("first_fetch", {63'd0, mem_read, mem_address}, {63'd1, 32'h0000_0100});
        wait_resp("fetch", n);
        imem_read = 1'b0;
        @(negedge clk);
        chk("fetch_one_cycle", {95'd0, imem_resp}, 96'd0);

        // dual-port batch: dmem served first
        dn_q.push_back('{32'h0000_2000, 1'b1, 1'b0, 4'd0, 32'd0, 32'hA5A5_0001, 2});
        dn_q.push_back('{32'h0000_1000, 1'b1, 1'b0, 4'd0, 32'd0, 32'h0000_0093, 3});
        up_q.push_back('{1'b1, 1'b1, 32'h0000_0093, 32'hA5A5_0001, 1});
        imem_read = 1'b1; imem_address = 32'h0000_1000;
        dmem_read = 1'b1; dmem_address = 32'h0000_2000;
        wait_resp("dual", n);
        imem_read = 1'b0; dmem_read = 1'b0;
        @(negedge clk);

        dn_q.push_back('{32'h0000_2004, 1'b0, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h1234_5678, 1});
        up_q.push_back('{1'b0, 1'b1, 32'd0, 32'd0, GAP1});
        dmem_write = 1'b1; dmem_address = 32'h0000_2004;
        dmem_wmask = 4'b0011; dmem_wdata = 32'hDEAD_BEEF;
        wait_resp("write", n);
        dmem_write = 1'b0;
        @(negedge clk);

        dn_q.push_back('{32'h0000_2010, 1'b0, 1'b1, 4'hF, 32'h0BAD_F00D, 32'hFFFF_FFFF, 2});
        up_q.push_back('{1'b0, 1'b1, 32'd0, 32'd0, GAP1});
        dmem_read = 1'b1; dmem_write = 1'b1; dmem_address = 32'h0000_2010;
        dmem_wmask = 4'hF; dmem_wdata = 32'h0BAD_F00D;
        wait_resp("rd_and_wr", n);
        dmem_read = 1'b0; dmem_write = 1'b0; dmem_wmask = 4'd0; dmem_wdata = 32'd0;
        @(negedge clk);

        dn_q.push_back('{32'h2000_0000, 1'b1, 1'b0, 4'd0, 32'd0, 32'hCAFE_F00D, 1});
        up_q.push_back('{1'b1, 1'b0, 32'hCAFE_F00D, 32'd0, GAP1});
        imem_read = 1'b1; imem_address = 32'h2000_0000;
        wait_resp("lat_l1", n);
        chk("latency_l1", 96'(n + 1), 96'(LAT1));
        imem_read = 1'b0;
        @(negedge clk);

        // dmem raised mid-batch joins the next batch
        dn_q.push_back('{32'h0000_1004, 1'b1, 1'b0, 4'd0, 32'd0, 32'h1111_1111, 3});
        dn_q.push_back('{32'h0000_3000, 1'b1, 1'b0, 4'd0, 32'd0, 32'h2222_2222, 2});
        up_q.push_back('{1'b1, 1'b0, 32'h1111_1111, 32'd0, GAP1});
        up_q.push_back('{1'b0, 1'b1, 32'd0, 32'h2222_2222, GAP1});
        imem_read = 1'b1; imem_address = 32'h0000_1004;
        @(negedge clk);
        dmem_read = 1'b1; dmem_address = 32'h0000_3000;
        wait_resp("late_i", n);
        imem_read = 1'b0;
        wait_resp("late_d", n);
        dmem_read = 1'b0;
        @(negedge clk);

        // reset while DMEM waits on a slow response
        dn_q.push_back('{32'h0000_2008, 1'b1, 1'b0, 4'd0, 32'd0, 32'h0000_0055, 10});
        dmem_read = 1'b1; dmem_address = 32'h0000_2008;
        repeat (3) @(negedge clk);
        chk("in_dmem", {63'd0, mem_read, mem_address}, {63'd1, 32'h0000_2008});
        rst = 1'b0;
        #1;
        chk("async_reset", {29'd0, mem_read, mem_write, imem_resp, dmem_resp, mem_address}, 96'd0);
        chk("async_reset_rdata", {32'd0, imem_rdata, dmem_rdata}, 96'd0);
        dmem_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        stray_req++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stray_ignored", {94'd0, imem_resp, dmem_resp}, 96'd0);
        end

        dn_q.push_back('{32'h0000_0040, 1'b1, 1'b0, 4'd0, 32'd0, 32'h0010_0073, 1});
        up_q.push_back('{1'b1, 1'b0, 32'h0010_0073, 32'd0, GAP1});
        imem_read = 1'b1; imem_address = 32'h0000_0040;
        wait_resp("after_reset", n);
        imem_read = 1'b0;
        repeat (3) @(negedge clk);

        chk("queues_empty", 96'(dn_q.size() + up_q.size()), 96'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
